gpa_fhdo_seq: RTL and testbench

//  Frame sequencer in front of gpa_fhdo_iface. Holds four per-channel 24-bit DAC words (x, y, z, z2), double-buffered.
//  On a software trigger or periodic timer tick, emits one 4-word frame on data_o/valid_o, then tracks busy_i until the SPI transfer ends.

---
 rtl/gpa_fhdo_seq_pkg.sv | 29 ++
 rtl/gpa_fhdo_seq_timer.sv | 38 +++
 rtl/gpa_fhdo_seq.sv | 179 +++++++++++++++++
 tb/tb_gpa_fhdo_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpa_fhdo_seq_pkg.sv
// Shared definitions for the gpa_fhdo frame sequencer: FSM encodings,
// data_o field positions, the init-frame word and the word packer.
package gpa_fhdo_seq_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_RDY  = 3'd1;
    localparam logic [2:0] ST_SEND0     = 3'd2;
    localparam logic [2:0] ST_SEND1     = 3'd3;
    localparam logic [2:0] ST_SEND2     = 3'd4;
    localparam logic [2:0] ST_SEND3     = 3'd5;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd6;
    localparam logic [2:0] ST_WAIT_DONE = 3'd7;

    localparam int CH_LSB   = 25;
    localparam int LAST_BIT = 24;

    localparam logic [23:0] INIT_WORD = 24'h030A00;

    // Channel 3 always closes the frame, so "last" follows from the channel.
    function automatic logic [31:0] pack_word(input logic [1:0] ch, input logic [23:0] word);
        logic [31:0] w;
        w               = 32'd0;
        w[CH_LSB +: 2]  = ch;
        w[LAST_BIT]     = (ch == 2'd3);
        w[23:0]         = word;
        return w;
    endfunction

endpackage

// File: rtl/gpa_fhdo_seq_timer.sv
// Auto-trigger period counter: one-cycle tick every period_i cycles;
// a period of 0 or any change of period_i restarts the count at 0.
module gpa_fhdo_seq_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] period_i,
    output logic        tick_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] period_q;

    // Next count and tick decode.
    always_comb begin
        tick_o  = 1'b0;
        count_d = count_q;
        if ((period_i == 32'd0) || (period_i != period_q)) begin
            count_d = 32'd0;
        end else if (count_q == (period_i - 32'd1)) begin
            tick_o  = 1'b1;
            count_d = 32'd0;
        end else begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter and last-seen period registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 32'd0;
            period_q <= 32'd0;
        end else begin
            count_q  <= count_d;
            period_q <= period_i;
        end
    end

endmodule

// File: rtl/gpa_fhdo_seq.sv
// Frame sequencer feeding gpa_fhdo_iface: four double-buffered 24-bit DAC
// words sent as one burst per trigger. Optional GPA_FHDO_SEQ_INIT_EN runs an init frame after reset.
module gpa_fhdo_seq
    import gpa_fhdo_seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_ch_i,
    input  logic [23:0]      wr_data_i,
    input  logic             trig_i,
    input  logic [31:0]      period_i,
    input  logic             clear_err_i,
    input  logic             busy_i,
    output logic [31:0]      data_o,
    output logic             valid_o,
    output logic             frame_busy_o,
    output logic             done_o,
    output logic             overrun_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int             AW       = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [AW-1:0]  ACK_LAST = AW'(ACK_TIMEOUT - 1);
    localparam logic [AW-1:0]  ACK_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0][23:0]  staging_q, shadow_q, shadow_d;
    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     ack_cnt_q, ack_cnt_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d, fbusy_q, fbusy_d, done_q, done_d;
    logic              overrun_q, overrun_d, timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_s, trig_s, init_pend_s, timeout_set_s, cnt_inc_s;
    logic [2:0]        send_idx_s;
    logic [1:0]        ch_s;

    gpa_fhdo_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .period_i (period_i),
        .tick_o   (tick_s)
    );

    assign trig_s = trig_i | tick_s;

`ifdef GPA_FHDO_SEQ_INIT_EN
    logic init_pend_q;

    // Pending automatic init frame, consumed by the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_pend_q <= 1'b1;
        end else if (state_q == ST_IDLE) begin
            init_pend_q <= 1'b0;
        end else begin
            init_pend_q <= init_pend_q;
        end
    end

    assign init_pend_s = init_pend_q;
`else
    assign init_pend_s = 1'b0;
`endif

    // Frame FSM next state.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        ack_cnt_d     = ack_cnt_q;
        done_d        = 1'b0;
        timeout_set_s = 1'b0;
        cnt_inc_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_pend_s) begin
                    shadow_d = {4{INIT_WORD}};
                    state_d  = ST_WAIT_RDY;
                end else if (trig_s) begin
                    shadow_d = staging_q;
                    state_d  = ST_WAIT_RDY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (!busy_i) state_d = ST_SEND0;
                else         state_d = ST_WAIT_RDY;
            end
            ST_SEND0: state_d = ST_SEND1;
            ST_SEND1: state_d = ST_SEND2;
            ST_SEND2: state_d = ST_SEND3;
            ST_SEND3: begin
                state_d   = ST_WAIT_ACK;
                ack_cnt_d = '0;
            end
            ST_WAIT_ACK: begin
                if (busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d       = ST_IDLE;
                    done_d        = 1'b1;
                    timeout_set_s = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy_i) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    cnt_inc_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and status next values; outputs follow the next state so they line up with it.
    always_comb begin
        valid_d    = (state_d >= ST_SEND0) && (state_d <= ST_SEND3);
        send_idx_s = state_d - ST_SEND0;
        ch_s       = send_idx_s[1:0];
        if (valid_d) data_d = pack_word(ch_s, shadow_d[ch_s]);
        else         data_d = 32'd0;
        fbusy_d = (state_d != ST_IDLE);
        if (clear_err_i) overrun_d = 1'b0;
        else             overrun_d = overrun_q | (trig_s & ((state_q != ST_IDLE) | init_pend_s));
        if (clear_err_i) timeout_d = 1'b0;
        else             timeout_d = timeout_q | timeout_set_s;
        if (cnt_inc_s) cnt_d = cnt_q + CNT_ONE;
        else           cnt_d = cnt_q;
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            staging_q <= '0;
            shadow_q  <= '0;
            ack_cnt_q <= '0;
            data_q    <= 32'd0;
            valid_q   <= 1'b0;
            fbusy_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            ack_cnt_q <= ack_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fbusy_q   <= fbusy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            if (wr_en_i) staging_q[wr_ch_i] <= wr_data_i;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_busy_o = fbusy_q;
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;
    assign timeout_o    = timeout_q;
    assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_gpa_fhdo_seq.sv
// Self-checking bench for gpa_fhdo_seq: directed table, corner sequences and
// randomized frames against a staging-array model plus an iface busy stub.
module tb_gpa_fhdo_seq;

    localparam int ACK_TO = 16;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             wr_en = 1'b0, trig = 1'b0, clear = 1'b0;
    logic [1:0]       wr_ch = 2'd0;
    logic [23:0]      wr_data = 24'd0;
    logic [31:0]      period = 32'd0;
    logic             busy_force = 1'b0, stub_busy = 1'b0;
    logic             busy;
    logic [31:0]      data_o;
    logic             valid_o, frame_busy_o, done_o, overrun_o, timeout_o;
    logic [CNT_W-1:0] frame_cnt_o;

    assign busy = busy_force | stub_busy;

    gpa_fhdo_seq #(.ACK_TIMEOUT(ACK_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_data_i(wr_data),
        .trig_i(trig), .period_i(period), .clear_err_i(clear), .busy_i(busy),
        .data_o(data_o), .valid_o(valid_o), .frame_busy_o(frame_busy_o), .done_o(done_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0, errors = 0;
    int exp_cnt = 0;
    logic [3:0][23:0] st = '0;
    logic [31:0] cap [4];
    int t_first = 0;
    bit rnd_wr = 1'b0;
    bit stub_en = 1'b1;
    int ack_dly = 2, busy_len = 5;

    typedef struct packed {
        logic [3:0][23:0] w;
        logic [3:0][31:0] e;
    } vec_t;
    vec_t tbl [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Iface stand-in: busy rises ack_dly cycles after the last word, stays busy_len cycles.
    initial forever begin
        @(posedge clk); #2;
        if (stub_en && valid_o && data_o[24]) begin
            repeat (ack_dly) @(posedge clk);
            #2 stub_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #2 stub_busy = 1'b0;
        end
    end

    task automatic cyc();
        if (rnd_wr && !wr_en && ($urandom_range(0, 2) == 0)) begin
            wr_en   = 1'b1;
            wr_ch   = 2'($urandom_range(0, 3));
            wr_data = 24'($urandom);
        end
        @(posedge clk); #1;
        if (wr_en) st[wr_ch] = wr_data;
        wr_en = 1'b0; trig = 1'b0; clear = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [23:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        cyc();
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (valid_o) begin ok = 1'b1; break; end
            cyc();
        end
    endtask

    task automatic wait_done(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (done_o) begin ok = 1'b1; break; end
        end
        chk({nm, " done"}, 32'(ok), 32'd1);
    endtask

    task automatic collect(input logic [3:0][23:0] w, input string nm, input int lim);
        bit ok;
        wait_valid(lim, ok);
        chk({nm, " start"}, 32'(ok), 32'd1);
        if (ok) begin
            t_first = cyc_n;
            for (int k = 0; k < 4; k++) begin
                cap[k] = data_o;
                chk($sformatf("%s w%0d", nm, k), data_o, {5'd0, 2'(k), (k == 3), w[k]});
                chk($sformatf("%s v%0d", nm, k), 32'(valid_o), 32'd1);
                cyc();
            end
            chk({nm, " tail"}, 32'(valid_o), 32'd0);
        end
    endtask

    task automatic after_reset();
        st = '0;
`ifdef GPA_FHDO_SEQ_INIT_EN
        collect({4{24'h030A00}}, "init", 20);
        wait_done("init");
        exp_cnt = 1;
        chk("init cnt", 32'(frame_cnt_o), 32'd1);
`else
        begin
            int nd = 0;
            for (int i = 0; i < 6; i++) begin cyc(); if (done_o || valid_o) nd++; end
            chk("no auto frame", 32'(nd), 32'd0);
        end
`endif
    endtask

    initial begin
        logic [3:0][23:0] snap;
        bit ok;
        int nv, n, t_prev;

        tbl[0].w = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
        tbl[0].e = {32'h07000004, 32'h04000003, 32'h02000002, 32'h00000001};
        tbl[1].w = {24'h123456, 24'h800000, 24'h000000, 24'hFFFFFF};
        tbl[1].e = {32'h07123456, 32'h04800000, 32'h02000000, 32'h00FFFFFF};
        tbl[2].w = {24'hFFFFFF, 24'h000001, 24'hABCDEF, 24'h030A00};
        tbl[2].e = {32'h07FFFFFF, 32'h04000001, 32'h02ABCDEF, 32'h00030A00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst data", data_o, 32'd0);
        chk("rst fbusy", 32'(frame_busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst ovr", 32'(overrun_o), 32'd0);
        chk("rst tmo", 32'(timeout_o), 32'd0);
        chk("rst cnt", 32'(frame_cnt_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        after_reset();

        // Table-driven frames with latency check.
        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c < 4; c++) wr(2'(c), tbl[v].w[c]);
            trig = 1'b1; cyc();
            chk("lat1", 32'(valid_o), 32'd0);
            chk("fbusy launch", 32'(frame_busy_o), 32'd1);
            cyc();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("tbl%0d w%0d", v, k), data_o, tbl[v].e[k]);
                chk($sformatf("tbl%0d v%0d", v, k), 32'(valid_o), 32'd1);
                cyc();
            end
            chk("tbl tail", 32'(valid_o), 32'd0);
            wait_done("tbl");
            exp_cnt++;
            chk("tbl cnt", 32'(frame_cnt_o), 32'(exp_cnt));
            chk("tbl fbusy end", 32'(frame_busy_o), 32'd0);
            chk("tbl ovr", 32'(overrun_o), 32'd0);
            chk("tbl tmo", 32'(timeout_o), 32'd0);
        end

        // Iface busy at trigger holds the frame back.
        busy_force = 1'b1;
        snap = st; trig = 1'b1; cyc();
        nv = 0;
        for (int i = 0; i < 50; i++) begin if (valid_o) nv++; cyc(); end
        chk("busy hold", 32'(nv), 32'd0);
        chk("busy fbusy", 32'(frame_busy_o), 32'd1);
        busy_force = 1'b0;
        collect(snap, "busy", 10);
        wait_done("busy");
        exp_cnt++;
        chk("busy cnt", 32'(frame_cnt_o), 32'(exp_cnt));

        // Trigger during WAIT_DONE is an overrun and is dropped.
        ack_dly = 1; busy_len = 30;
        snap = st; trig = 1'b1; cyc();
        collect(snap, "ovr", 10);
        for (int i = 0; i < 20 && !busy; i++) cyc();
        cyc();
        trig = 1'b1; cyc();
        chk("ovr set", 32'(overrun_o), 32'd1);
        wait_done("ovr");
        exp_cnt++;
        chk("ovr cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        nv = 0;
        for (int i = 0; i < 20; i++) begin if (valid_o) nv++; cyc(); end
        chk("ovr dropped", 32'(nv), 32'd0);
        chk("ovr sticky", 32'(overrun_o), 32'd1);
        clear = 1'b1; cyc();
        chk("ovr clear", 32'(overrun_o), 32'd0);
        snap = st; trig = 1'b1; cyc();
        collect(snap, "clrwin", 10);
        trig = 1'b1; clear = 1'b1; cyc();
        chk("clear wins", 32'(overrun_o), 32'd0);
        wait_done("clrwin");
        exp_cnt++;
        ack_dly = 2; busy_len = 5;

        // Write ch1 during SEND1: current frame keeps old word.
        wr(2'd1, 24'h000002);
        snap = st; trig = 1'b1; cyc();
        wait_valid(10, ok);
        chk("mid w0", data_o, {8'h00, snap[0]});
        cyc();
        wr_en = 1'b1; wr_ch = 2'd1; wr_data = 24'h000006;
        chk("mid w1 old", data_o, 32'h02000002);
        cyc();
        chk("mid w2", data_o, {8'h04, snap[2]});
        cyc(); cyc();
        wait_done("mid");
        exp_cnt++;
        snap = st; trig = 1'b1; cyc();
        collect(snap, "mid next", 10);
        chk("mid next w1 new", cap[1], 32'h02000006);
        wait_done("mid next");
        exp_cnt++;

        // Periodic timer: 5 frames, 2000-cycle spacing.
        period = 32'd2000;
        t_prev = 0;
        for (int f = 0; f < 5; f++) begin
            collect(st, "timer", 2100);
            if (f > 0) chk("timer spacing", 32'(t_first - t_prev), 32'd2000);
            t_prev = t_first;
            if (f == 4) period = 32'd0;
            wait_done("timer");
            exp_cnt++;
        end
        chk("timer cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        chk("timer ovr", 32'(overrun_o), 32'd0);

        // No acknowledge from the iface: timeout.
        stub_en = 1'b0;
        snap = st; trig = 1'b1; cyc();
        collect(snap, "tmo", 10);
        n = 0;
        for (int i = 0; i < 40 && !timeout_o; i++) begin cyc(); n++; end
        chk("tmo delay", 32'(n), 32'(ACK_TO));
        chk("tmo done", 32'(done_o), 32'd1);
        chk("tmo fbusy", 32'(frame_busy_o), 32'd0);
        chk("tmo cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        clear = 1'b1; cyc();
        chk("tmo clear", 32'(timeout_o), 32'd0);
        stub_en = 1'b1;

        // Randomized frames with writes every few cycles and occasional overruns.
        rnd_wr = 1'b1;
        for (int it = 0; it < 25; it++) begin
            bit ovr;
            ack_dly  = $urandom_range(0, 10);
            busy_len = $urandom_range(1, 20);
            repeat ($urandom_range(0, 5)) cyc();
            snap = st; trig = 1'b1; cyc();
            collect(snap, "rnd", 10);
            ovr = ($urandom_range(0, 2) == 0);
            if (ovr) begin trig = 1'b1; cyc(); end
            wait_done("rnd");
            exp_cnt++;
            chk("rnd cnt", 32'(frame_cnt_o), 32'(exp_cnt));
            chk("rnd ovr", 32'(overrun_o), 32'(ovr));
            clear = 1'b1; cyc();
            chk("rnd ovr clr", 32'(overrun_o), 32'd0);
        end
        rnd_wr = 1'b0;
        ack_dly = 2; busy_len = 5;
        repeat (30) cyc();

        // Async reset mid-frame aborts immediately.
        snap = st; trig = 1'b1; cyc();
        wait_valid(10, ok);
        cyc(); cyc();
        chk("pre-rst w2", data_o, {8'h04, snap[2]});
        rst_n = 1'b0;
        #1;
        chk("arst valid", 32'(valid_o), 32'd0);
        chk("arst fbusy", 32'(frame_busy_o), 32'd0);
        chk("arst done", 32'(done_o), 32'd0);
        chk("arst cnt", 32'(frame_cnt_o), 32'd0);
        stub_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 0;
        after_reset();
        snap = st; trig = 1'b1; cyc();
        collect(snap, "post-rst", 10);
        chk("post-rst zero w1", cap[1], 32'h02000000);
        wait_done("post-rst");
        exp_cnt++;
        chk("post-rst cnt", 32'(frame_cnt_o), 32'(exp_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
